// File: rtl/histo_pkg.sv
// ============================================================================
//  Module      : histo_pkg
//  Description : Shared constants, error encodings and receiver state type
//                for the histogram serial link receive path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package histo_pkg;

    localparam int HISTO_WORD_BITS   = 32;
    localparam int HISTO_NUM_BINS    = 1024;
    localparam int HISTO_SPACER_BITS = 8;
    localparam int HISTO_COUNT_BITS  = 24;

    // error_code bit 0 = truncated frame, bit 1 = nonzero spacer seen
    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_TRUNC  = 2'b01;
    localparam logic [1:0] ERR_SPACER = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/histo_spi_receiver_edge_sync.sv
// ============================================================================
//  Module      : spi_edge_sync
//  Description : Brings the asynchronous serial clock and data into the clk
//                domain, detects serial-clock rising edges and presents the
//                data bit captured with the same alignment as the edge.
//                edge_pulse / edge_bit appear two clk edges after the first
//                clk edge that samples the serial clock high.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic edge_pulse,
    output logic edge_bit
);

    logic clk_meta;
    logic clk_sync;
    logic clk_prev;
    logic dat_meta;
    logic dat_sync;

    // Two-flop synchronizers plus a registered rising-edge detect; the data
    // path uses the same depth so the bit lines up with its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta   <= 1'b0;
            clk_sync   <= 1'b0;
            clk_prev   <= 1'b0;
            dat_meta   <= 1'b0;
            dat_sync   <= 1'b0;
            edge_pulse <= 1'b0;
            edge_bit   <= 1'b0;
        end else begin
            clk_meta   <= spi_clk;
            clk_sync   <= clk_meta;
            clk_prev   <= clk_sync;
            dat_meta   <= spi_mosi;
            dat_sync   <= dat_meta;
            edge_pulse <= clk_sync & ~clk_prev;
            edge_bit   <= dat_sync;
        end
    end

endmodule

`default_nettype wire

// File: rtl/histo_spi_receiver.sv
// ============================================================================
//  Module      : histo_spi_receiver
//  Description : Receive end of the histogram serial link. Deserializes
//                MSB-first 32-bit words, maps them onto bins (word 0 carries
//                the last bin and the frame number), and reports truncated
//                frames and nonzero spacers.
//                Optional: HISTO_RX_SUM_EN adds a per-frame sum of all bin
//                counts on total_count, valid with frame_done.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module histo_spi_receiver
    import histo_pkg::*;
#(
    parameter int WORD_BITS  = HISTO_WORD_BITS,
    parameter int NUM_BINS   = HISTO_NUM_BINS,
    parameter int GAP_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        spi_clk_i,
    input  logic        spi_mosi_i,
    output logic        bin_valid,
    output logic [9:0]  bin_index,
    output logic [23:0] bin_count,
    output logic [7:0]  frame_number,
    output logic        frame_done,
    output logic        frame_error,
    output logic [1:0]  error_code,
    output logic        busy
`ifdef HISTO_RX_SUM_EN
    ,
    output logic [33:0] total_count
`endif
);

    localparam int BIT_W = $clog2(WORD_BITS);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_BITS - 1);
    localparam logic [9:0]       LAST_WORD = 10'(NUM_BINS - 1);
    localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(GAP_CYCLES);

    rx_state_e              state;
    rx_state_e              state_nxt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [WORD_BITS-2:0]   shift;
    logic [BIT_W-1:0]       bit_cnt;
    logic [9:0]             word_idx;
    logic                   word_pend;
    logic [WORD_BITS-1:0]   word;
    logic [1:0]             err;
    logic                   edge_pulse;
    logic                   edge_bit;

    logic                   gap_ok;
    logic                   start;
    logic                   active;
    logic                   last_word;
    logic                   spacer_hit;
    logic [WORD_BITS-1:0]   shifted;
    logic [HISTO_SPACER_BITS-1:0] spacer;
    logic [HISTO_COUNT_BITS-1:0]  count;

    spi_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (reset),
        .spi_clk    (spi_clk_i),
        .spi_mosi   (spi_mosi_i),
        .edge_pulse (edge_pulse),
        .edge_bit   (edge_bit)
    );

    assign gap_ok     = (gap_cnt == GAP_MAX);
    assign start      = (state == IDLE) && enable && edge_pulse && gap_ok;
    assign active     = (state == RECV) && enable;
    assign last_word  = active && word_pend && (word_idx == LAST_WORD);
    assign shifted    = {shift, edge_bit};
    assign spacer     = word[WORD_BITS-1 -: HISTO_SPACER_BITS];
    assign count      = word[HISTO_COUNT_BITS-1:0];
    assign spacer_hit = active && word_pend && (word_idx != 10'd0) && (spacer != '0);

    assign frame_done  = (state == DONE);
    assign frame_error = (state == DONE) && (err != ERR_NONE);
    assign error_code  = err;
    assign busy        = (state == RECV);

`ifdef HISTO_RX_SUM_EN
    logic [33:0] acc;
    logic [33:0] acc_nxt;
    assign acc_nxt = word_pend ? (acc + {10'd0, count}) : acc;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: a gap while receiving means the frame was cut short
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RECV;
            RECV: begin
                if (!enable)                 state_nxt = IDLE;
                else if (last_word || gap_ok) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gap timing, bit assembly, word-to-bin mapping and error collection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt      <= '0;
            shift        <= '0;
            bit_cnt      <= '0;
            word_idx     <= '0;
            word_pend    <= 1'b0;
            word         <= '0;
            err          <= ERR_NONE;
            bin_valid    <= 1'b0;
            bin_index    <= '0;
            bin_count    <= '0;
            frame_number <= '0;
`ifdef HISTO_RX_SUM_EN
            acc          <= '0;
            total_count  <= '0;
`endif
        end else begin
            if (edge_pulse)  gap_cnt <= '0;
            else if (!gap_ok) gap_cnt <= gap_cnt + 1'b1;

            bin_valid <= 1'b0;

            if (start) begin
                shift     <= {{(WORD_BITS-2){1'b0}}, edge_bit};
                bit_cnt   <= BIT_W'(1);
                word_idx  <= '0;
                word_pend <= 1'b0;
                err       <= ERR_NONE;
`ifdef HISTO_RX_SUM_EN
                acc       <= '0;
`endif
            end else if (active) begin
                word_pend <= 1'b0;
                if (edge_pulse) begin
                    shift <= shifted[WORD_BITS-2:0];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt   <= '0;
                        word_pend <= 1'b1;
                        word      <= shifted;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (word_pend) begin
                    bin_valid <= 1'b1;
                    bin_count <= count;
                    word_idx  <= word_idx + 1'b1;
                    if (word_idx == 10'd0) begin
                        bin_index    <= LAST_WORD;
                        frame_number <= spacer;
                    end else begin
                        bin_index <= word_idx - 10'd1;
                    end
                end
                err <= err | (spacer_hit ? ERR_SPACER : ERR_NONE)
                           | (gap_ok     ? ERR_TRUNC  : ERR_NONE);
`ifdef HISTO_RX_SUM_EN
                acc <= acc_nxt;
`endif
            end else begin
                // idle, done or aborted: nothing partial survives
                shift     <= '0;
                bit_cnt   <= '0;
                word_idx  <= '0;
                word_pend <= 1'b0;
            end

`ifdef HISTO_RX_SUM_EN
            if ((state == RECV) && (state_nxt == DONE)) total_count <= acc_nxt;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_histo_spi_receiver.sv
// ============================================================================
//  Module      : tb_histo_spi_receiver
//  Description : Directed self-checking bench for histo_spi_receiver, run
//                with a reduced frame length (NB bins) to keep frames short.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_histo_spi_receiver;

    localparam int NB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        spi_clk_i = 1'b0;
    logic        spi_mosi_i = 1'b0;
    logic        bin_valid;
    logic [9:0]  bin_index;
    logic [23:0] bin_count;
    logic [7:0]  frame_number;
    logic        frame_done;
    logic        frame_error;
    logic [1:0]  error_code;
    logic        busy;
`ifdef HISTO_RX_SUM_EN
    logic [33:0] total_count;
    logic [33:0] d_total;
`endif

    histo_spi_receiver #(.NUM_BINS(NB), .GAP_CYCLES(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .spi_clk_i    (spi_clk_i),
        .spi_mosi_i   (spi_mosi_i),
        .bin_valid    (bin_valid),
        .bin_index    (bin_index),
        .bin_count    (bin_count),
        .frame_number (frame_number),
        .frame_done   (frame_done),
        .frame_error  (frame_error),
        .error_code   (error_code),
        .busy         (busy)
`ifdef HISTO_RX_SUM_EN
        ,
        .total_count  (total_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observation side: everything sampled on the falling edge
    int          nv;
    int          nd;
    int          lat;
    int          last_rise;
    int          w0_rise;
    logic [9:0]  idx_a [0:63];
    logic [23:0] cnt_a [0:63];
    logic        d_err;
    logic [1:0]  d_code;

    always @(negedge clk) begin
        if (bin_valid) begin
            if (nv == 0) lat = cyc - w0_rise;
            if (nv < 64) begin
                idx_a[nv] = bin_index;
                cnt_a[nv] = bin_count;
            end
            nv++;
        end
        if (frame_done) begin
            nd++;
            d_err  = frame_error;
            d_code = error_code;
`ifdef HISTO_RX_SUM_EN
            d_total = total_count;
`endif
        end
    end

    task automatic clear_mon();
        nv = 0; nd = 0; lat = -1; d_err = 1'b0; d_code = 2'b00;
    endtask

    // One serial bit: two clk low (data changes here), two clk high
    task automatic send_bit(input logic b);
        @(negedge clk);
        spi_mosi_i = b;
        spi_clk_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        spi_clk_i  = 1'b1;
        last_rise  = cyc;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic first);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
        if (first) w0_rise = last_rise;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        spi_clk_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Words 0..nw-1 of a frame: word 0 = {fnum, NB-1}, word j = {0, j-1}
    task automatic send_frame(input logic [7:0] fnum, input int nw, input int bad, input logic ones);
        logic [31:0] w;
        for (int j = 0; j < nw; j++) begin
            w = (j == 0) ? {fnum, 24'(NB - 1)} : {8'h00, 24'(j - 1)};
            if (ones) w[23:0] = 24'hFFFFFF;
            if (j == bad) w[31:24] = 8'h01;
            send_word(w, j == 0);
        end
    endtask

    task automatic check_bins(input string tag, input int nexp);
        int errs;
        logic [9:0] ei;
        errs = 0;
        check({tag, "_nvalid"}, nv, nexp);
        for (int k = 0; k < nexp && k < nv && k < 64; k++) begin
            ei = (k == 0) ? 10'(NB - 1) : 10'(k - 1);
            if (idx_a[k] !== ei || cnt_a[k] !== 24'(ei)) errs++;
        end
        check({tag, "_bins_bad"}, errs, 0);
    endtask

    initial begin
        clear_mon();
        last_rise = 0;
        w0_rise   = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", bin_valid, 0);
        check("rst_index", bin_index, 0);
        check("rst_fnum",  frame_number, 0);
        check("rst_done",  {frame_done, frame_error, error_code, busy}, 0);

        reset  = 1'b1;
        enable = 1'b1;
        idle(80);

        // Good frame
        clear_mon();
        send_frame(8'h5A, NB, -1, 1'b0);
        idle(80);
        check_bins("good", NB);
        check("good_idx0", idx_a[0], NB - 1);
        check("good_fnum", frame_number, 8'h5A);
        check("good_latency", lat, 5);
        check("good_done", nd, 1);
        check("good_ferr", d_err, 0);
        check("good_code", d_code, 2'b00);
        check("good_busy_after", busy, 0);

        // Truncated: 10 words plus 13 bits, then a gap
        clear_mon();
        send_frame(8'h11, 10, -1, 1'b0);
        for (int i = 0; i < 13; i++) send_bit(1'b1);
        check("trunc_busy_mid", busy, 1);
        idle(80);
        check_bins("trunc", 10);
        check("trunc_done", nd, 1);
        check("trunc_ferr", d_err, 1);
        check("trunc_code", d_code, 2'b01);

        // Spacer error on word 7
        clear_mon();
        send_frame(8'h22, NB, 7, 1'b0);
        idle(80);
        check_bins("spacer", NB);
        check("spacer_idx7", idx_a[7], 6);
        check("spacer_fnum", frame_number, 8'h22);
        check("spacer_done", nd, 1);
        check("spacer_ferr", d_err, 1);
        check("spacer_code", d_code, 2'b10);

        // Enable raised in the middle of a frame
        enable = 1'b0;
        clear_mon();
        for (int j = 0; j < 5; j++) send_word({8'h00, 24'(j)}, 1'b0);
        enable = 1'b1;
        for (int j = 5; j < NB; j++) send_word({8'h00, 24'(j)}, 1'b0);
        idle(80);
        check("midena_nvalid", nv, 0);
        check("midena_done", nd, 0);
        clear_mon();
        send_frame(8'h33, NB, -1, 1'b0);
        idle(80);
        check_bins("midena_next", NB);
        check("midena_next_done", nd, 1);
        check("midena_next_ferr", d_err, 0);
        check("midena_next_fnum", frame_number, 8'h33);

        // Abort through enable after 10 words
        clear_mon();
        send_frame(8'h66, 10, -1, 1'b0);
        idle(10);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy", busy, 0);
        idle(80);
        check("abort_nvalid", nv, 10);
        check("abort_done", nd, 0);
        enable = 1'b1;

        // Reset pulse in the middle of a frame
        clear_mon();
        send_frame(8'h77, 5, -1, 1'b0);
        send_bit(1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rmid_index", bin_index, 0);
        check("rmid_count", bin_count, 0);
        check("rmid_fnum",  frame_number, 0);
        check("rmid_flags", {bin_valid, frame_done, frame_error, error_code, busy}, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(80);
        check("rmid_done", nd, 0);
        clear_mon();
        send_frame(8'h44, NB, -1, 1'b0);
        idle(80);
        check_bins("after_rst", NB);
        check("after_rst_done", nd, 1);
        check("after_rst_ferr", d_err, 0);
        check("after_rst_fnum", frame_number, 8'h44);

`ifdef HISTO_RX_SUM_EN
        // All counts 0xFFFFFF: NB * 0xFFFFFF = 0xFFFFFF0 for NB=16
        clear_mon();
        send_frame(8'h55, NB, -1, 1'b1);
        idle(80);
        check("sum_done", nd, 1);
        check("sum_total", d_total, 64'h0FFF_FFF0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
